pc_fetch: RTL

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake. A one-entry fetch buffer holds each returned instruction until the IF/ID register takes it. The stage also absorbs pipeline stalls (`bbl`) and branch redirects, discarding any in-flight fetch that a redirect makes stale.

---
 rtl/pc_fetch_pkg.sv | 21 ++
 rtl/fetch_buf.sv | 34 +++
 rtl/pc_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage types: bus widths, word constants and fetch FSM encodings.
package pc_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic        Branch     = 1'b1;
  localparam logic        BblDisable = 1'b0;

  typedef enum logic [1:0] {
    FetchRun     = 2'd0,
    FetchWait    = 2'd1,
    FetchDiscard = 2'd2
  } fetch_state_t;

  function automatic logic [InstAddrBus-1:0] pc_inc(input logic [InstAddrBus-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Single-entry fetch buffer: holds {pc, inst} until consumed.
// Load is visible next cycle; flush beats load, a load with consume replaces the entry.
module fetch_buf
  import pc_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   consume,
  input  logic                   flush,
  input  logic [InstAddrBus-1:0] ld_pc,
  input  logic [InstBus-1:0]     ld_inst,
  output logic                   valid,
  output logic [InstAddrBus-1:0] pc,
  output logic [InstBus-1:0]     inst
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= ZeroWord;
      inst  <= ZeroWord;
    end else begin
      if (flush)        valid <= 1'b0;
      else if (load)    valid <= 1'b1;
      else if (consume) valid <= 1'b0;
      if (load && !flush) begin
        pc   <= ld_pc;
        inst <= ld_inst;
      end
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: owns the PC, issues req/ack word fetches, buffers one result for IF/ID.
// Zero-wait memory gives one instruction per cycle; bbl holds the buffer and blocks new requests.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bbl,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic                   imem_req_o,
  output logic [InstAddrBus-1:0] imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [InstBus-1:0]     imem_rdata_i,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   stallreq_o
);

  fetch_state_t           state, state_nxt;
  logic [InstAddrBus-1:0] pc_q, req_addr_q;
  logic                   buf_valid;
  logic [InstAddrBus-1:0] buf_pc;
  logic [InstBus-1:0]     buf_inst;
  logic                   redirect, consume;
  logic                   req_int, load;
  logic [InstAddrBus-1:0] ld_pc;

  assign redirect = (branch_flag_i == Branch) && (bbl == BblDisable);
  assign consume  = buf_valid && (bbl == BblDisable) && (branch_flag_i != Branch);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FetchRun;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FetchRun:     if (req_int && !imem_ack_i) state_nxt = FetchWait;
      FetchWait:    if (imem_ack_i)             state_nxt = FetchRun;
                    else if (redirect)          state_nxt = FetchDiscard;
      FetchDiscard: if (imem_ack_i)             state_nxt = FetchRun;
      default:                                  state_nxt = FetchRun;
    endcase
  end

  // Data returned in DISCARD, or alongside a redirect, is stale and never loaded.
  always_comb begin
    req_int     = 1'b0;
    imem_addr_o = pc_q;
    load        = 1'b0;
    ld_pc       = pc_q;
    case (state)
      FetchRun: begin
        req_int = !redirect && (!buf_valid || consume);
        load    = req_int && imem_ack_i;
      end
      FetchWait: begin
        req_int     = 1'b1;
        imem_addr_o = req_addr_q;
        load        = imem_ack_i && !redirect;
        ld_pc       = req_addr_q;
      end
      FetchDiscard: begin
        req_int     = 1'b1;
        imem_addr_o = req_addr_q;
      end
      default: ;
    endcase
  end

  assign imem_req_o = req_int && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      if (redirect)
        pc_q <= branch_target_i;
      else if (state == FetchRun && req_int)
        pc_q <= pc_inc(pc_q);
      if (state == FetchRun && req_int && !imem_ack_i)
        req_addr_q <= pc_q;
    end
  end

  fetch_buf u_fetch_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .consume (consume),
    .flush   (redirect),
    .ld_pc   (ld_pc),
    .ld_inst (imem_rdata_i),
    .valid   (buf_valid),
    .pc      (buf_pc),
    .inst    (buf_inst)
  );

  assign if_pc      = buf_valid ? buf_pc   : ZeroWord;
  assign if_inst    = buf_valid ? buf_inst : ZeroWord;
  assign stallreq_o = !buf_valid;

endmodule
